pipeline_rx_fifo: RTL

Synchronous receiver that sits directly downstream of `asynchronous_pipeline`. It consumes the pipeline's 4-phase request/ack output (`request_out`, `data_out`, `ack_in`) and brings each token into the `clk` domain. Tokens are buffered in a small FIFO and presented on a valid/ready interface to clocked logic. Backpressure is applied by withholding the ack, so no token is ever dropped.

---
 rtl/pipeline_rx_pkg.sv | 14 +
 rtl/rx_sync_fifo.sv | 59 +++++
 rtl/pipeline_rx_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/pipeline_rx_pkg.sv
// Shared types and default parameters for the pipeline receiver.
package pipeline_rx_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACK    = 2'd2
  } rx_state_t;

  localparam int DATA_W_DEF      = 4;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/rx_sync_fifo.sv
// Show-ahead synchronous FIFO; pushes when full and pops when empty are dropped.
module rx_sync_fifo
  import pipeline_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_b_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              push_en, pop_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_rx_fifo.sv
// Receives 4-phase req/ack tokens from the async pipeline into the clk domain
// and presents them on a valid/ready port; backpressure withholds the ack.
//
// state  | meaning
// RESYNC | after reset: wait out chain fill, then until req_s is low
// IDLE   | ack low; capture on req_s when FIFO has room
// ACK    | ack high; wait for req_s to fall
module pipeline_rx_fifo
  import pipeline_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     request_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ack_out,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int HW = $clog2(SYNC_STAGES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = SYNC_STAGES[HW-1:0];

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  rx_state_t              state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   ack_q;
  logic                   push;
  logic                   full, empty;

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], request_in};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  // The chain is cleared by reset, so RESYNC must let it refill before
  // trusting a low req_s; otherwise a request held across reset is recaptured.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push    = 1'b0;
    case (state_q)
      RESYNC: begin
        if (hold_q != '0)  hold_d  = hold_q - 1'b1;
        else if (!req_s)   state_d = IDLE;
      end
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESYNC;
      hold_q  <= HOLD_LOAD;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ack_q   <= (state_d == ACK);
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = !empty;

  rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_b_i (reset),
    .push_i  (push),
    .wdata_i (data_in),
    .pop_i   (out_ready),
    .rdata_o (out_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
